// File: rtl/ibex_pkg.sv
// Shared ibex types: multiply/divide op codes and divider FSM states.
// Pure declarations; no logic, no latency, no flow control.
package ibex_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL,
    MD_OP_MULH,
    MD_OP_DIV,
    MD_OP_REM
  } md_op_e;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_PREP,
    DIV_ITER,
    DIV_FINISH
  } div_fsm_e;

  parameter int unsigned DIV_MAX_WIDTH = 64;

endpackage

// File: rtl/ibex_div_iter.sv
// Iterative radix-2 restoring divider (DIV/DIVU/REM/REMU), Width+2 cycles, or 2 on early-out/MUL ops.
// Result is held until out_ready_i; in_ready_o is only high in IDLE; kill_i aborts from any state.
module ibex_div_iter
  import ibex_pkg::*;
#(
  parameter int unsigned Width    = 32,
  parameter bit          EarlyOut = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  md_op_e           op_i,
  input  logic             signed_i,
  input  logic [Width-1:0] op_a_i,
  input  logic [Width-1:0] op_b_i,
  input  logic             kill_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] result_o,
  output logic             out_err_o,
  output logic             busy_o
);

  localparam int unsigned      CntW   = $clog2(Width + 1);
  localparam logic [CntW-1:0]  CntOne = 1;
  localparam logic [Width-1:0] MinVal = {1'b1, {(Width-1){1'b0}}};

  div_fsm_e         state_q;
  md_op_e           op_q;
  logic             signed_q;
  logic [Width-1:0] a_q, b_q;
  logic [Width-1:0] quo_q, div_q, rem_q;
  logic [CntW-1:0]  cnt_q;
  logic             quo_neg_q, rem_neg_q;
  logic             out_valid_q, out_err_q;
  logic [Width-1:0] result_q;

  logic             a_neg, b_neg, div_zero, sgn_ovf, is_mul;
  logic [Width-1:0] a_abs, b_abs;
  logic [Width:0]   shifted, trial;
  logic             trial_ge;
  logic [Width-1:0] fin_res;

  assign a_neg    = signed_q & a_q[Width-1];
  assign b_neg    = signed_q & b_q[Width-1];
  assign a_abs    = a_neg ? -a_q : a_q;
  assign b_abs    = b_neg ? -b_q : b_q;
  assign div_zero = (b_q == '0);
  assign sgn_ovf  = signed_q & (a_q == MinVal) & (b_q == '1);
  assign is_mul   = (op_q == MD_OP_MULL) || (op_q == MD_OP_MULH);

  // One restoring step: bring in the next dividend bit, keep the difference if it did not borrow.
  assign shifted  = {rem_q, quo_q[Width-1]};
  assign trial    = shifted - {1'b0, div_q};
  assign trial_ge = (shifted >= {1'b0, div_q});

  always_comb begin
    fin_res = '0;
    if (is_mul) begin
      fin_res = '0;
    end else if (div_zero) begin
      fin_res = (op_q == MD_OP_DIV) ? '1 : a_q;
    end else if (sgn_ovf) begin
      fin_res = (op_q == MD_OP_DIV) ? a_q : '0;
    end else if (op_q == MD_OP_DIV) begin
      fin_res = quo_neg_q ? -quo_q : quo_q;
    end else begin
      fin_res = rem_neg_q ? -rem_q : rem_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= DIV_IDLE;
      op_q        <= MD_OP_MULL;
      signed_q    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      quo_neg_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      result_q    <= '0;
    end else if (kill_i) begin
      state_q     <= DIV_IDLE;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (in_valid_i) begin
            op_q     <= op_i;
            signed_q <= signed_i;
            a_q      <= op_a_i;
            b_q      <= op_b_i;
            state_q  <= DIV_PREP;
          end
        end
        DIV_PREP: begin
          quo_q     <= a_abs;
          div_q     <= b_abs;
          rem_q     <= '0;
          cnt_q     <= CntW'(Width);
          quo_neg_q <= a_neg ^ b_neg;
          rem_neg_q <= a_neg;
          if (is_mul || (EarlyOut && (div_zero || sgn_ovf))) begin
            state_q <= DIV_FINISH;
          end else begin
            state_q <= DIV_ITER;
          end
        end
        DIV_ITER: begin
          rem_q <= trial_ge ? trial[Width-1:0] : shifted[Width-1:0];
          quo_q <= {quo_q[Width-2:0], trial_ge};
          cnt_q <= cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            state_q <= DIV_FINISH;
          end
        end
        DIV_FINISH: begin
          // First FINISH cycle applies signs and registers the result; then wait for the consumer.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            result_q    <= fin_res;
            out_err_q   <= is_mul;
          end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            state_q     <= DIV_IDLE;
          end
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end

  assign in_ready_o  = (state_q == DIV_IDLE);
  assign busy_o      = (state_q != DIV_IDLE);
  assign out_valid_o = out_valid_q;
  assign out_err_o   = out_err_q;
  assign result_o    = result_q;

endmodule

// File: tb/tb_ibex_div_iter.sv
// Self-checking bench: three divider instances (32/EarlyOut, 32/full latency, 64/EarlyOut) against an arithmetic model.
module tb_ibex_div_iter;
  import ibex_pkg::*;

  localparam int WD [3] = '{32, 32, 64};
  localparam bit EOD[3] = '{1'b1, 1'b0, 1'b1};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        sgn = 1'b0;
  logic        kill = 1'b0;
  logic        out_ready = 1'b1;
  md_op_e      op = MD_OP_DIV;
  logic [63:0] a = '0, b = '0;

  logic [2:0]  ir, ov, er, bz;
  logic [31:0] r0, r1;
  logic [63:0] r2;
  logic [63:0] rs [3];

  always #5 clk = ~clk;

  assign rs[0] = {32'd0, r0};
  assign rs[1] = {32'd0, r1};
  assign rs[2] = r2;

  ibex_div_iter #(.Width(32), .EarlyOut(1'b1)) u_d32e (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(ir[0]), .op_i(op),
    .signed_i(sgn), .op_a_i(a[31:0]), .op_b_i(b[31:0]), .kill_i(kill), .out_valid_o(ov[0]),
    .out_ready_i(out_ready), .result_o(r0), .out_err_o(er[0]), .busy_o(bz[0]));

  ibex_div_iter #(.Width(32), .EarlyOut(1'b0)) u_d32n (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(ir[1]), .op_i(op),
    .signed_i(sgn), .op_a_i(a[31:0]), .op_b_i(b[31:0]), .kill_i(kill), .out_valid_o(ov[1]),
    .out_ready_i(out_ready), .result_o(r1), .out_err_o(er[1]), .busy_o(bz[1]));

  ibex_div_iter #(.Width(64), .EarlyOut(1'b1)) u_d64e (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(ir[2]), .op_i(op),
    .signed_i(sgn), .op_a_i(a), .op_b_i(b), .kill_i(kill), .out_valid_o(ov[2]),
    .out_ready_i(out_ready), .result_o(r2), .out_err_o(er[2]), .busy_o(bz[2]));

  int          n_tests = 0, n_fail = 0;
  int          cyc = 0;
  int          acc = 0;
  int          iss_id = 0, cancel_id = 0;
  int          got_id [3] = '{0, 0, 0};
  logic [63:0] e_res [3];
  logic        e_err [3];
  int          e_lat [3];
  logic [2:0]  pov = 3'b000;
  logic        prdy = 1'b1;
  logic [63:0] prs [3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] wmask(input int w);
    return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  // Reference result from RISC-V division rules using native 64-bit arithmetic.
  function automatic logic [63:0] model(input int w, input logic s, input md_op_e o,
                                        input logic [63:0] x, input logic [63:0] y);
    logic [63:0] m;
    longint      sx, sy;
    m = wmask(w);
    x = x & m;
    y = y & m;
    if (o == MD_OP_MULL || o == MD_OP_MULH) return 64'd0;
    if (y == 64'd0) return (o == MD_OP_DIV) ? m : x;
    if (!s) return (o == MD_OP_DIV) ? (x / y) : (x % y);
    if (x == (64'd1 << (w - 1)) && y == m) return (o == MD_OP_DIV) ? x : 64'd0;
    sx = longint'(x << (64 - w)) >>> (64 - w);
    sy = longint'(y << (64 - w)) >>> (64 - w);
    return ((o == MD_OP_DIV) ? 64'(sx / sy) : 64'(sx % sy)) & m;
  endfunction

  function automatic int lat(input int w, input bit eo, input logic s, input md_op_e o,
                             input logic [63:0] x, input logic [63:0] y);
    logic [63:0] m;
    bit          special;
    m = wmask(w);
    if (o == MD_OP_MULL || o == MD_OP_MULH) return 2;
    special = ((y & m) == 64'd0) || (s && ((x & m) == (64'd1 << (w - 1))) && ((y & m) == m));
    return (special && eo) ? 2 : w + 2;
  endfunction

  function automatic bit pend(input int d);
    return (iss_id != got_id[d]) && (iss_id != cancel_id);
  endfunction

  // Compare process: result/err/latency on the first valid cycle, stability while stalled.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (ov[d] && !pov[d]) begin
        if (!pend(d)) begin
          chk($sformatf("unexpected_valid%0d", d), 64'(ov[d]), 64'd0);
        end else begin
          chk($sformatf("result%0d_id%0d", d, iss_id), rs[d], e_res[d]);
          chk($sformatf("err%0d_id%0d", d, iss_id), 64'(er[d]), 64'(e_err[d]));
          chk($sformatf("latency%0d_id%0d", d, iss_id), 64'(cyc - acc), 64'(e_lat[d]));
          got_id[d] = iss_id;
        end
      end
      if (pov[d] && !prdy) begin
        chk($sformatf("hold_valid%0d", d), 64'(ov[d]), 64'd1);
        chk($sformatf("hold_result%0d", d), rs[d], prs[d]);
      end
      if (pov[d] && prdy) chk($sformatf("valid_drop%0d", d), 64'(ov[d]), 64'd0);
      if (ov[d]) chk($sformatf("in_ready_low%0d", d), 64'(ir[d]), 64'd0);
      pov[d] = ov[d];
      prs[d] = rs[d];
    end
    prdy = out_ready;
  end

  task automatic issue(input logic s, input md_op_e o, input logic [63:0] x, input logic [63:0] y);
    int g;
    g = 0;
    while (ir != 3'b111 && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    chk("ready_before_issue", 64'(ir), 64'h7);
    for (int d = 0; d < 3; d++) begin
      e_res[d] = model(WD[d], s, o, x, y);
      e_err[d] = (o == MD_OP_MULL || o == MD_OP_MULH);
      e_lat[d] = lat(WD[d], EOD[d], s, o, x, y);
    end
    iss_id++;
    sgn = s; op = o; a = x; b = y;
    in_valid = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input bit rnd);
    int g;
    g = 0;
    while ((pend(0) || pend(1) || pend(2)) && g < 400) begin
      @(posedge clk); #1;
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      g++;
    end
    if (g >= 400) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout id%0d: pending results %b%b%b after %0d cycles",
               iss_id, pend(2), pend(1), pend(0), g);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] x, y;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(ov), 64'h0);
    chk("rst_err", 64'(er), 64'h0);
    chk("rst_busy", 64'(bz), 64'h0);
    chk("rst_ready", 64'(ir), 64'h7);
    chk("rst_res32", rs[0], 64'd0);
    chk("rst_res64", rs[2], 64'd0);
    rst_n = 1'b1;

    chk("pin_divu", model(32, 1'b0, MD_OP_DIV, 64'd100, 64'd7), 64'd14);
    chk("pin_remu", model(32, 1'b0, MD_OP_REM, 64'd100, 64'd7), 64'd2);
    chk("pin_div_s", model(32, 1'b1, MD_OP_DIV, 64'hFFFF_FFF9, 64'd2), 64'hFFFF_FFFD);
    chk("pin_rem_s", model(32, 1'b1, MD_OP_REM, 64'hFFFF_FFF9, 64'd2), 64'hFFFF_FFFF);
    chk("pin_dz", model(32, 1'b0, MD_OP_DIV, 64'd5, 64'd0), 64'hFFFF_FFFF);
    chk("pin_ovf", model(32, 1'b1, MD_OP_DIV, 64'h8000_0000, 64'hFFFF_FFFF), 64'h8000_0000);
    chk("pin64_div", model(64, 1'b1, MD_OP_DIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7), 64'hFFFF_FFFF_FFFF_FFF2);
    chk("pin64_rem", model(64, 1'b1, MD_OP_REM, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7), 64'hFFFF_FFFF_FFFF_FFFE);

    issue(1'b0, MD_OP_DIV, 64'd100, 64'd7);                                      wait_done(1'b0);
    issue(1'b0, MD_OP_REM, 64'd100, 64'd7);                                      wait_done(1'b0);
    issue(1'b1, MD_OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);                      wait_done(1'b0);
    issue(1'b1, MD_OP_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);                      wait_done(1'b0);
    issue(1'b0, MD_OP_DIV, 64'd5, 64'd0);                                        wait_done(1'b0);
    issue(1'b0, MD_OP_REM, 64'd5, 64'd0);                                        wait_done(1'b0);
    issue(1'b1, MD_OP_DIV, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF);    wait_done(1'b0);
    issue(1'b1, MD_OP_REM, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF);    wait_done(1'b0);
    issue(1'b1, MD_OP_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);    wait_done(1'b0);
    issue(1'b1, MD_OP_DIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7);                      wait_done(1'b0);
    issue(1'b1, MD_OP_REM, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7);                      wait_done(1'b0);
    issue(1'b0, MD_OP_MULL, 64'd3, 64'd4);                                       wait_done(1'b0);
    issue(1'b1, MD_OP_MULH, 64'd3, 64'd0);                                       wait_done(1'b0);

    // Kill during the tenth iteration, then a fresh request must still work.
    issue(1'b0, MD_OP_DIV, 64'd100, 64'd7);
    repeat (10) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    cancel_id = iss_id;
    @(negedge clk);
    chk("kill_busy", 64'(bz), 64'h0);
    chk("kill_valid", 64'(ov), 64'h0);
    issue(1'b0, MD_OP_DIV, 64'd9, 64'd3);                                        wait_done(1'b0);

    // Kill coincident with a request in IDLE drops the request.
    @(posedge clk); #1;
    in_valid = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    @(negedge clk);
    chk("kill_idle_busy", 64'(bz), 64'h0);

    // Consumer stalls long enough that every instance holds its result.
    out_ready = 1'b0;
    issue(1'b0, MD_OP_DIV, 64'd1000, 64'd10);
    repeat (75) @(posedge clk);
    #1 chk("stall_all_valid", 64'(ov), 64'h7);
    out_ready = 1'b1;
    wait_done(1'b0);

    // Asynchronous reset mid-iteration clears state without a clock edge.
    issue(1'b0, MD_OP_DIV, 64'd100, 64'd7);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(bz), 64'h0);
    chk("arst_ready", 64'(ir), 64'h7);
    chk("arst_valid", 64'(ov), 64'h0);
    cancel_id = iss_id;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 80; i++) begin
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        1: y = 64'($urandom_range(1, 20));
        2: y = 64'd0;
        3: begin x = {$urandom, 32'h8000_0000}; y = 64'hFFFF_FFFF_FFFF_FFFF; end
        4: begin x = 64'h8000_0000_0000_0000; y = 64'hFFFF_FFFF_FFFF_FFFF; end
        5: begin x = 64'($urandom); y = {32'hFFFF_FFFF, $urandom}; end
        default: ;
      endcase
      issue(1'($urandom_range(0, 1)), md_op_e'($urandom_range(0, 3)), x, y);
      wait_done(1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
